// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/BUSY/DONE, one access per three cycles.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority to port 0 instead of round-robin.
module dmem_arbiter #(
  parameter int ADDRESS_LINE = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDRESS_LINE-1:0] p0_addr,
  input  logic [7:0]              p0_wdata,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDRESS_LINE-1:0] p1_addr,
  input  logic [7:0]              p1_wdata,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [7:0]              rdata,
  output logic [ADDRESS_LINE-1:0] mem_address,
  output logic [7:0]              mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [7:0]              mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  logic   win_id;
  logic   any_req;
  logic   pick;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = p0_req | p1_req;
    pick    = ~p0_req;
  end
`else
  logic last;

  // pick = 1 selects port 1; on a tie the port that lost last time wins
  always_comb begin
    any_req = p0_req | p1_req;
    pick    = (p0_req && p1_req) ? ~last : p1_req;
  end
`endif

  // mem_* registers double as the latched request while BUSY
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      win_id         <= 1'b0;
      p0_gnt         <= 1'b0;
      p1_gnt         <= 1'b0;
      p0_rvalid      <= 1'b0;
      p1_rvalid      <= 1'b0;
      rdata          <= 8'h00;
      mem_address    <= '0;
      mem_write_data <= 8'h00;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last           <= 1'b1;
`endif
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state          <= BUSY;
            win_id         <= pick;
            p0_gnt         <= ~pick;
            p1_gnt         <= pick;
            mem_address    <= pick ? p1_addr : p0_addr;
            mem_write_data <= pick ? p1_wdata : p0_wdata;
            mem_write      <= pick ? p1_we : p0_we;
            mem_read       <= pick ? ~p1_we : ~p0_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last           <= pick;
`endif
          end
        end
        BUSY: begin
          state          <= DONE;
          if (mem_read) rdata <= mem_read_data;
          p0_rvalid      <= ~win_id;
          p1_rvalid      <= win_id;
          mem_address    <= '0;
          mem_write_data <= 8'h00;
          mem_write      <= 1'b0;
          mem_read       <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-wide memory model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0]  rdata;
  logic [15:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_write, mem_read;
  logic [7:0]  mem_read_data;

  logic [7:0] mem [256] = '{default: 8'h00};

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ntest = 0;
  int   nfail = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDRESS_LINE(16)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clock)
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

  // completion monitor: every rvalid pops the oldest expectation
  always @(negedge clock) begin
    if (p0_rvalid || p1_rvalid) begin
      ntest++;
      if (p0_rvalid && p1_rvalid) begin
        nfail++;
        $display("FAIL rvalid_both: got 11 want one-hot");
      end else if (sb.size() == 0) begin
        nfail++;
        $display("FAIL rvalid_extra: got rvalid p%0d want none", p1_rvalid);
      end else begin
        e = sb.pop_front();
        if (p1_rvalid !== e.port) begin
          nfail++;
          $display("FAIL rvalid_port: got p%0d want p%0d", p1_rvalid, e.port);
        end
        if (!e.we) begin
          ntest++;
          if (rdata !== e.data) begin
            nfail++;
            $display("FAIL rdata: got %h want %h", rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (2) @(negedge clock);
    ntest++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0) begin
      nfail++;
      $display("FAIL reset_pulses: got %b want 0000",
               {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid});
    end
    ntest++;
    if ({mem_write, mem_read, mem_address, mem_write_data} !== 26'h0) begin
      nfail++;
      $display("FAIL reset_mem: got %b%b %h %h want 0", mem_write,
               mem_read, mem_address, mem_write_data);
    end
    ntest++;
    if (rdata !== 8'h00) begin
      nfail++;
      $display("FAIL reset_rdata: got %h want 00", rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    ntest++;
    if ({p0_gnt, p1_gnt, mem_write, mem_read} !== 4'b0) begin
      nfail++;
      $display("FAIL idle_quiet: got %b want 0000",
               {p0_gnt, p1_gnt, mem_write, mem_read});
    end
  endtask

  task automatic test_p0_write();
    sb.push_back('{1'b0, 1'b1, 8'h00});
    p0_req = 1; p0_we = 1; p0_addr = 16'h0010; p0_wdata = 8'hA5;
    @(negedge clock);
    ntest++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      nfail++;
      $display("FAIL wr_gnt: got %b want 10", {p0_gnt, p1_gnt});
    end
    ntest++;
    if ({mem_write, mem_read} !== 2'b10 || mem_address !== 16'h0010 ||
        mem_write_data !== 8'hA5) begin
      nfail++;
      $display("FAIL wr_bus: got %b%b %h %h want 10 0010 a5", mem_write,
               mem_read, mem_address, mem_write_data);
    end
    p0_req = 0;
    @(negedge clock);
    ntest++;
    if (p0_rvalid !== 1'b1 || p0_gnt !== 1'b0 || mem_write !== 1'b0) begin
      nfail++;
      $display("FAIL wr_done: got rv=%b gnt=%b mw=%b want 1 0 0",
               p0_rvalid, p0_gnt, mem_write);
    end
    ntest++;
    if (rdata !== 8'h00) begin
      nfail++;
      $display("FAIL wr_rdata: got %h want 00", rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_p1_read();
    int rd = 0;
    sb.push_back('{1'b1, 1'b0, 8'hA5});
    p1_req = 1; p1_we = 0; p1_addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (mem_read) rd++;
      if (i == 0) begin
        p1_req = 0;
        ntest++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || mem_address !== 16'h0010) begin
          nfail++;
          $display("FAIL rd_gnt: got %b %h want 01 0010",
                   {p0_gnt, p1_gnt}, mem_address);
        end
      end
      if (i == 1) begin
        ntest++;
        if (p1_rvalid !== 1'b1 || rdata !== 8'hA5) begin
          nfail++;
          $display("FAIL rd_done: got rv=%b %h want 1 a5", p1_rvalid, rdata);
        end
      end
    end
    ntest++;
    if (rd != 1) begin
      nfail++;
      $display("FAIL rd_pulse: got %0d cycles want 1", rd);
    end
  endtask

  task automatic test_write_then_read();
    sb.push_back('{1'b0, 1'b1, 8'h00});
    p0_req = 1; p0_we = 1; p0_addr = 16'h0030; p0_wdata = 8'h3C;
    @(negedge clock);
    p0_req = 0;
    @(negedge clock);
    ntest++;
    if (rdata !== 8'hA5) begin
      nfail++;
      $display("FAIL wtr_hold: got %h want a5", rdata);
    end
    @(negedge clock);
    sb.push_back('{1'b0, 1'b0, 8'h00});
    p0_req = 1; p0_we = 0; p0_addr = 16'h0020;
    @(negedge clock);
    p0_req = 0;
    repeat (5) @(negedge clock);
    ntest++;
    if (rdata !== 8'h00) begin
      nfail++;
      $display("FAIL wtr_keep: got %h want 00", rdata);
    end
  endtask

  task automatic test_addr_hold();
    sb.push_back('{1'b1, 1'b0, 8'h3C});
    sb.push_back('{1'b1, 1'b0, 8'h00});
    p1_req = 1; p1_we = 0; p1_addr = 16'h0030;
    @(negedge clock);
    p1_addr = 16'h0055;
    #1;
    ntest++;
    if (p1_gnt !== 1'b1 || mem_address !== 16'h0030) begin
      nfail++;
      $display("FAIL hold_addr: got gnt=%b %h want 1 0030", p1_gnt,
               mem_address);
    end
    @(negedge clock);
    ntest++;
    if (mem_address !== 16'h0000 || mem_read !== 1'b0) begin
      nfail++;
      $display("FAIL hold_clear: got %h %b want 0000 0", mem_address,
               mem_read);
    end
    @(negedge clock);
    ntest++;
    if ({p0_gnt, p1_gnt} !== 2'b00) begin
      nfail++;
      $display("FAIL hold_gap: got %b want 00", {p0_gnt, p1_gnt});
    end
    @(negedge clock);
    ntest++;
    if (p1_gnt !== 1'b1 || mem_address !== 16'h0055) begin
      nfail++;
      $display("FAIL rereq: got gnt=%b %h want 1 0055", p1_gnt, mem_address);
    end
    p1_req = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_busy();
    p0_req = 1; p0_we = 1; p0_addr = 16'h0040; p0_wdata = 8'h77;
    @(negedge clock);
    ntest++;
    if (p0_gnt !== 1'b1) begin
      nfail++;
      $display("FAIL rb_gnt: got %b want 1", p0_gnt);
    end
    reset = 1; p0_req = 0;
    @(negedge clock);
    ntest++;
    if ({p0_rvalid, p1_rvalid, p0_gnt, mem_write, mem_read} !== 5'b0 ||
        mem_address !== 16'h0 || mem_write_data !== 8'h0) begin
      nfail++;
      $display("FAIL rb_abort: got %b %h %h want 0",
               {p0_rvalid, p1_rvalid, p0_gnt, mem_write, mem_read},
               mem_address, mem_write_data);
    end
    ntest++;
    if (rdata !== 8'h00) begin
      nfail++;
      $display("FAIL rb_rdata: got %h want 00", rdata);
    end
    reset = 0;
    @(negedge clock);
    ntest++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      nfail++;
      $display("FAIL rb_late: got %b want 00", {p0_rvalid, p1_rvalid});
    end
  endtask

  task automatic test_round_robin();
    logic exp_port [4];
    int   g = 0;
    int   last_cyc = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) sb.push_back('{exp_port[i], 1'b1, 8'h00});
    p0_req = 1; p0_we = 1; p0_addr = 16'h0060; p0_wdata = 8'h11;
    p1_req = 1; p1_we = 1; p1_addr = 16'h0061; p1_wdata = 8'h22;
    for (int c = 1; c <= 20 && g < 4; c++) begin
      @(negedge clock);
      if (p0_gnt || p1_gnt) begin
        ntest++;
        if ((p0_gnt && p1_gnt) || p1_gnt !== exp_port[g]) begin
          nfail++;
          $display("FAIL rr_winner%0d: got %b want p%0d", g,
                   {p0_gnt, p1_gnt}, exp_port[g]);
        end
        if (g > 0) begin
          ntest++;
          if (c - last_cyc != 3) begin
            nfail++;
            $display("FAIL rr_space: got %0d want 3", c - last_cyc);
          end
        end
        last_cyc = c;
        g++;
      end
    end
    p0_req = 0; p1_req = 0;
    ntest++;
    if (g != 4) begin
      nfail++;
      $display("FAIL rr_count: got %0d grants want 4", g);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_p1();
    sb.push_back('{1'b1, 1'b1, 8'h00});
    p1_req = 1; p1_we = 1; p1_addr = 16'h0070; p1_wdata = 8'h99;
    @(negedge clock);
    p1_req = 0;
    ntest++;
    if ({p0_gnt, p1_gnt} !== 2'b01) begin
      nfail++;
      $display("FAIL single_p1: got %b want 01", {p0_gnt, p1_gnt});
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_p0_write();
    test_p1_read();
    test_write_then_read();
    test_addr_hold();
    test_reset_busy();
    test_round_robin();
    test_single_p1();
    ntest++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_LINE, default 16, the address width of every port and of the memory bus.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports pN_req  input  1  access request from port N, for N = 0 (pipeline MEM stage) and N = 1 (debug/DMA).
REQ-005 SHALL have ports pN_we  input  1  write when 1, read when 0.
REQ-006 SHALL have ports pN_addr  input  ADDRESS_LINE  access address.
REQ-007 SHALL have ports pN_wdata  input  8  write data.
REQ-008 SHALL have ports pN_gnt  output  1  one-cycle grant pulse.
REQ-009 SHALL have ports pN_rvalid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  8  registered read data, shared by both ports.
REQ-011 SHALL have ports mem_address  output  ADDRESS_LINE; mem_write_data  output  8; mem_write  output  1; mem_read  output  1. These drive the data memory.
REQ-012 SHALL have port mem_read_data  input  8  combinational read data from the memory.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE, no pN_req high at the edge: SHALL stay in IDLE.
REQ-015 IDLE, any pN_req high at edge N: SHALL select a winner, latch its we/addr/wdata and the winner id, and go to BUSY.
REQ-016 At that same edge N, SHALL register gnt high for the winner only, so the grant is visible in cycle N+1 for exactly one cycle.
REQ-017 BUSY: SHALL drive mem_address and mem_write_data from the latched values.
REQ-018 BUSY: SHALL drive mem_write = latched we and mem_read = NOT latched we.
REQ-019 Outside BUSY: SHALL hold mem_write, mem_read, mem_address and mem_write_data at 0.
REQ-020 BUSY to DONE at edge N+1: SHALL capture mem_read_data into rdata on reads; rdata SHALL be unchanged on writes.
REQ-021 At edge N+1: SHALL register winner rvalid high for both reads and writes, visible in cycle N+2 for one cycle.
REQ-022 DONE: SHALL return to IDLE unconditionally; peak rate is one access per 3 cycles.
REQ-023 Request signals SHALL be sampled only in IDLE; changes during BUSY or DONE SHALL be ignored.
REQ-024 A requester holding req after its rvalid SHALL be treated as a new request at the next IDLE sample.
REQ-025 Single requester: that port SHALL win.
REQ-026 Both ports requesting: the port that did not win last SHALL win (round-robin); the last-winner pointer SHALL update at each grant.
REQ-027 rdata SHALL hold its value until the next read completes.

Reset
REQ-028 Reset SHALL force IDLE; gnt, rvalid, rdata, the latched request and all mem_* outputs SHALL be 0.
REQ-029 Reset SHALL set the last-winner pointer to port 1, so port 0 wins the first tie.
REQ-030 Reset asserted in BUSY or DONE SHALL abandon the transaction; no rvalid SHALL follow.

Configuration
REQ-031 Macro DMEM_ARB_FIXED_PRIO_EN defined: ties SHALL always go to port 0, and the last-winner pointer SHALL not exist.
REQ-032 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin arbitration as in REQ-026.

Verification
REQ-033 Port 0 write: addr 0x0010, wdata 0xA5 -> p0_gnt in cycle 1, mem_write=1 and mem_address=0x0010 in cycle 1, p0_rvalid in cycle 2.
REQ-034 Port 1 read of 0x0010 after REQ-033 -> p1_rvalid with rdata=0xA5 two cycles after the request edge; mem_read high for exactly one cycle.
REQ-035 Both ports request continuously from reset -> grants alternate 0,1,0,1, spaced 3 cycles apart; with DMEM_ARB_FIXED_PRIO_EN, grants are 0,0,0,0.
REQ-036 Reset asserted in BUSY -> next cycle: state IDLE, no rvalid, all mem_* = 0.
REQ-037 p1_addr changed during BUSY -> mem_address keeps the value latched at grant.
REQ-038 Port 0 write of 0x3C, then port 0 read of 0x0020 returning 0x00 -> rdata=0x00 after the read; rdata does not change during the write.
